// File: rtl/stream_gen.sv
// AXI-Stream test-pattern source (counter, PRBS-31, fixed, walking) with
// exact word counts, single-word error injection and a 4-register IPIF slave.
module stream_gen #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_REG              = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    input  logic                            IPIF_Bus2IP_resetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   IPIF_Bus2IP_Addr,
    input  logic                            IPIF_Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_Bus2IP_BE,
    input  logic [0:0]                      IPIF_Bus2IP_CS,
    input  logic [N_REG-1:0]                IPIF_Bus2IP_RdCE,
    input  logic [N_REG-1:0]                IPIF_Bus2IP_WrCE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_IP2Bus_Data,
    output logic                            IPIF_IP2Bus_WrAck,
    output logic                            IPIF_IP2Bus_RdAck,
    output logic                            IPIF_IP2Bus_Error
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [DW-1:0] ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] M_CNT   = 2'd0;
    localparam logic [1:0] M_PRBS  = 2'd1;
    localparam logic [1:0] M_FIXED = 2'd2;

    state_t        state_q;
    logic          en_q, en_prev_q, inj_q, cont_q, tvalid_q;
    logic [1:0]    mode_q;
    logic [DW-1:0] seed_q, count_q, sent_q, remain_q, pat_q, rdata_q;
    logic [30:0]   prbs_q;
    logic          wrack_q, rdack_q;

    logic          rst_all, hs, start, last_word;
    logic [DW-1:0] pat_d, rd_d, ctrl_rd;
    logic [30:0]   prbs_d, prbs_seed;
    logic [DW+30:0] start_prbs, adv_prbs;

    logic unused_ok;
    assign unused_ok = ^{IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE,
                         IPIF_Bus2IP_CS, IPIF_Bus2IP_WrCE[N_REG-1:3]};

    // Runs the x^31+x^28+1 LFSR for DW steps; first bit lands in the MSB.
    // Returns {word, state after the word}.
    function automatic logic [DW+30:0] prbs_word(input logic [30:0] s_in);
        logic [30:0]   s;
        logic [DW-1:0] w;
        logic          fb;
        s = s_in;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            fb          = s[30] ^ s[27];
            s           = {s[29:0], fb};
            w[DW-1-i]   = fb;
        end
        return {w, s};
    endfunction

    assign rst_all   = reset | ~IPIF_Bus2IP_resetn;
    assign hs        = tvalid_q & M_AXIS_TREADY;
    assign start     = (state_q == S_IDLE) & en_q & ~en_prev_q;
    assign last_word = ~cont_q & (remain_q == ONE);
    assign prbs_seed = (seed_q[30:0] == 31'd0) ? 31'h7FFFFFFF : seed_q[30:0];
    assign start_prbs = prbs_word(prbs_seed);
    assign adv_prbs   = prbs_word(prbs_q);

    always_comb begin
        pat_d  = pat_q;
        prbs_d = prbs_q;
        if (start) begin
            if (mode_q == M_PRBS) {pat_d, prbs_d} = start_prbs;
            else                  pat_d = seed_q;
        end else if (hs) begin
            case (mode_q)
                M_CNT:   pat_d = pat_q + ONE;
                M_PRBS:  {pat_d, prbs_d} = adv_prbs;
                M_FIXED: pat_d = pat_q;
                default: pat_d = {pat_q[DW-2:0], pat_q[DW-1]};
            endcase
        end
    end

    always_comb begin
        ctrl_rd      = '0;
        ctrl_rd[0]   = en_q;
        ctrl_rd[2:1] = mode_q;
        ctrl_rd[4]   = inj_q;
        ctrl_rd[5]   = cont_q;
        ctrl_rd[9:8] = state_q;
        rd_d = '0;
        if (IPIF_Bus2IP_RdCE[0]) rd_d = rd_d | ctrl_rd;
        if (IPIF_Bus2IP_RdCE[1]) rd_d = rd_d | seed_q;
        if (IPIF_Bus2IP_RdCE[2]) rd_d = rd_d | count_q;
        if (IPIF_Bus2IP_RdCE[3]) rd_d = rd_d | sent_q;
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            inj_q     <= 1'b0;
            cont_q    <= 1'b0;
            mode_q    <= 2'd0;
            tvalid_q  <= 1'b0;
            seed_q    <= '0;
            count_q   <= '0;
            sent_q    <= '0;
            remain_q  <= '0;
            pat_q     <= '0;
            prbs_q    <= '0;
            rdata_q   <= '0;
            wrack_q   <= 1'b0;
            rdack_q   <= 1'b0;
        end else begin
            wrack_q   <= |IPIF_Bus2IP_WrCE;
            rdack_q   <= |IPIF_Bus2IP_RdCE;
            rdata_q   <= rd_d;
            en_prev_q <= en_q;
            pat_q     <= pat_d;
            prbs_q    <= prbs_d;
            if (IPIF_Bus2IP_WrCE[0]) begin
                en_q   <= IPIF_Bus2IP_Data[0];
                mode_q <= IPIF_Bus2IP_Data[2:1];
                cont_q <= IPIF_Bus2IP_Data[5];
            end
            if (IPIF_Bus2IP_WrCE[1]) seed_q  <= IPIF_Bus2IP_Data;
            if (IPIF_Bus2IP_WrCE[2]) count_q <= IPIF_Bus2IP_Data;
            // A new inject request wins over the clear of a concurrent handshake.
            if (IPIF_Bus2IP_WrCE[0] && IPIF_Bus2IP_Data[4]) inj_q <= 1'b1;
            else if (hs)                                    inj_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sent_q   <= '0;
                        remain_q <= count_q;
                        if (count_q == '0 && !cont_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q  <= S_RUN;
                            tvalid_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        if (sent_q != '1) sent_q <= sent_q + ONE;
                        remain_q <= remain_q - ONE;
                        if (!en_q) begin
                            state_q  <= S_IDLE;
                            tvalid_q <= 1'b0;
                        end else if (last_word) begin
                            state_q  <= S_DONE;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (!en_q) state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign M_AXIS_TVALID     = tvalid_q;
    assign M_AXIS_TDATA      = pat_q ^ {{(DW-1){1'b0}}, inj_q};
    assign IPIF_IP2Bus_Data  = rdata_q;
    assign IPIF_IP2Bus_WrAck = wrack_q;
    assign IPIF_IP2Bus_RdAck = rdack_q;
    assign IPIF_IP2Bus_Error = 1'b0;

endmodule

// File: doc/stream_gen.md
# stream_gen

Configurable AXI-Stream test-pattern source that sits directly upstream of `stream_compare`. It drives one of the compare inputs, or both through a fan-out. It generates counter, PRBS-31, fixed or walking patterns with exact word counts and single-word error injection. It is controlled through the same 4-register IPIF slave interface as the compare block.

## Interface
- `C_S_AXI_ADDR_WIDTH`, default 32: IPIF address width.
- `C_S_AXI_DATA_WIDTH`, default 32: IPIF data width and stream width.
- `N_REG`, default 4: number of IPIF registers. Must be 4.

- `clk`  in  1: single clock for the stream and the IPIF.
- `reset`  in  1: synchronous, active-high reset.
- `M_AXIS_TDATA`  out  32: pattern word.
- `M_AXIS_TVALID`  out  1: word valid.
- `M_AXIS_TREADY`  in  1: downstream ready.
- `IPIF_Bus2IP_resetn`  in  1: synchronous active-low register reset; has the same effect as `reset`.
- `IPIF_Bus2IP_Addr`, `IPIF_Bus2IP_RNW`, `IPIF_Bus2IP_BE`, `IPIF_Bus2IP_CS`  in: unused.
- `IPIF_Bus2IP_RdCE`, `IPIF_Bus2IP_WrCE`  in  N_REG: one-hot enables; bit i selects register i.
- `IPIF_Bus2IP_Data`  in  32: write data.
- `IPIF_IP2Bus_Data`  out  32: read data.
- `IPIF_IP2Bus_WrAck`, `IPIF_IP2Bus_RdAck`  out  1: acknowledges.
- `IPIF_IP2Bus_Error`  out  1: tied to 0.

## Operation
Registers:
- reg0 CTRL (R/W):
  - bit0 `enable`.
  - bits[2:1] `mode`: 0 counter, 1 PRBS-31, 2 fixed, 3 walking.
  - bit4 `inject`: write 1 to set the pending flag; reads return the pending flag.
  - bit5 `continuous`.
  - bits[9:8] read-only FSM state: 0 IDLE, 1 RUN, 2 DONE.
- reg1 SEED (R/W): seed, or the fixed value in mode 2.
- reg2 COUNT (R/W): number of words per run when `continuous`=0.
- reg3 SENT (RO): handshakes since the last start; saturates at 0xFFFFFFFF.

Register writes:
- A write happens in every cycle the corresponding `WrCE[i]` is high, so a held CE rewrites the same value.
- Writing 0 to reg0 bit4 does not clear a pending inject.

FSM:
- IDLE
  - `M_AXIS_TVALID`=0.
  - On `enable` going 0->1: load the pattern state from SEED, load remaining from COUNT, clear SENT, go to RUN.
  - If COUNT=0 and `continuous`=0, go straight to DONE and send no words.
- RUN
  - `M_AXIS_TVALID`=1.
  - `M_AXIS_TDATA` is the current pattern word, with bit0 inverted while inject is pending.
  - On a handshake: advance the pattern, increment SENT, decrement remaining, clear inject.
  - A handshake on the last word with `continuous`=0 goes to DONE.
  - Clearing `enable`: `M_AXIS_TVALID` stays high until the next handshake, then the FSM goes to IDLE (AXIS rule: valid is never withdrawn).
- DONE
  - `M_AXIS_TVALID`=0.
  - Writing `enable`=0 returns to IDLE. Re-enabling requires a 0->1 transition.

Patterns, where n = handshake index starting at 0:
- Counter: `M_AXIS_TDATA` = SEED + n, modulo 2^32, wraps silently.
- PRBS-31 (x^31+x^28+1):
  - 31-bit state; the seed is SEED[30:0]. An all-zero seed is replaced by 31'h7FFFFFFF.
  - Per bit: fb = s[30]^s[27]; s = {s[29:0],fb}; output fb.
  - 32 bits are produced per word, computed in parallel in one cycle. The first bit goes to TDATA[31].
- Fixed: `M_AXIS_TDATA` = SEED for every word.
- Walking: SEED rotated left by n mod 32.

Pattern, inject and counters only change on handshake or on start. TREADY stalls never advance them.

Reset (`reset`=1 or `IPIF_Bus2IP_resetn`=0), including mid-run:
- All registers go to 0 and the FSM goes to IDLE.
- `M_AXIS_TVALID`, `M_AXIS_TDATA`, `IPIF_IP2Bus_Data` and both acks read 0 after the reset edge.
- A transfer in progress is abandoned.

## Timing
- WrAck = `|WrCE` registered: one-cycle latency, high for every cycle that CE was high one cycle earlier.
- RdAck = `|RdCE` registered. `IPIF_IP2Bus_Data` is registered alongside RdAck and is 0 when no read is acknowledged.
- Start latency:
  - The reg0 write that enables the block is captured at edge k.
  - The FSM enters RUN at edge k+1.
  - `M_AXIS_TVALID`=1 with the first word after edge k+1.
- Throughput: with TREADY held at 1, one word per cycle with no bubbles.
- Completion: the last handshake at edge m gives `M_AXIS_TVALID`=0 after edge m; state reads DONE from then on.
- `M_AXIS_TDATA` is stable for as long as TVALID=1 and TREADY=0.
- Simultaneous events: an inject write in the same cycle as a handshake applies to the following word.

## Test plan
- Counter mode, SEED=0x12345678, COUNT=4, TREADY=1 -> TDATA 0x12345678, 0x12345679, 0x1234567A, 0x1234567B on consecutive cycles; then TVALID=0, state=DONE, SENT=4.
- PRBS mode, SEED=1, COUNT=1 -> single word 0x00000012, SENT=1.
- Fixed mode, SEED=0x12345678, continuous, one inject write -> exactly one word 0x12345679, all other words 0x12345678, inject reads back 0 afterwards.
- Counter mode, SEED=0xFFFFFFFE, COUNT=3, TREADY toggling 1,0,0,1,1 -> words 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; TDATA held constant during the stalls; SENT=3.
- Continuous run, `enable` cleared while TREADY=0 -> TVALID stays 1 until TREADY=1, then 0; state=IDLE.
- COUNT=0 non-continuous start -> no TVALID pulse, state=DONE. `reset` pulsed mid-run -> TVALID=0, all registers read 0, WrAck follows each WrCE cycle by one clock.
